// File: rtl/draw_addr_sweep.sv
// Multi-lane address sweep generator for the draw path: walks [START_ADDR, END_ADDR)
// in groups of LANES consecutive addresses, one group per enabled cycle.
module draw_addr_sweep #(
    parameter int ADDR_W     = 14,
    parameter int LANES      = 2,
    parameter int START_ADDR = 13568,
    parameter int END_ADDR   = 13824
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      enable,
    input  logic                      loop,
    output logic [LANES*ADDR_W-1:0]   addr,
    output logic                      valid,
    output logic                      last,
    output logic                      wrapped,
    output logic                      done
);

    localparam int LG = $clog2(LANES);
    localparam int GW = ADDR_W - LG;
    localparam logic [GW-1:0] GS = GW'(START_ADDR / LANES);
    localparam logic [GW-1:0] GL = GW'(END_ADDR / LANES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] g, g_nxt;
    logic          wrap_nxt;

    // State, group counter and status flags all update together from the next-state logic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            g       <= GS;
            wrapped <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            g       <= g_nxt;
            wrapped <= wrap_nxt;
            valid   <= (state_nxt == RUN);
            done    <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        wrap_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    g_nxt     = GS;
                end
            end
            RUN: begin
                // Restart has priority over advancing; the final group either wraps or parks
                if (start) begin
                    g_nxt = GS;
                end else if (enable) begin
                    if (g != GL) begin
                        g_nxt = g + 1'b1;
                    end else if (loop) begin
                        g_nxt    = GS;
                        wrap_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    g_nxt     = GS;
                end
            end
            default: begin
                state_nxt = IDLE;
                g_nxt     = GS;
            end
        endcase
    end

    always_comb begin
        last = valid && (g == GL);
    end

    // Each lane appends its own index below the shared group number
    generate
        if (LG == 0) begin : g_single
            assign addr = g;
        end else begin : g_multi
            for (genvar i = 0; i < LANES; i++) begin : g_lane
                assign addr[i*ADDR_W +: ADDR_W] = {g, LG'(i)};
            end
        end
    endgenerate

endmodule

// File: tb/tb_draw_addr_sweep.sv
// Scoreboard bench for draw_addr_sweep: address-level reference model feeds a queue
// that a monitor drains every cycle; a second small instance covers a 4-lane window.
module tb_draw_addr_sweep;

    localparam int ADDR_W = 14;
    localparam int LANES  = 2;
    localparam int START  = 13568;
    localparam int END    = 13824;

    logic clk = 1'b0;
    logic reset, start, enable, loop;
    logic [LANES*ADDR_W-1:0] addr;
    logic valid, last, wrapped, done;

    logic s_start, s_enable, s_loop;
    logic [23:0] s_addr;
    logic s_valid, s_last, s_wrapped, s_done;

    always #5 clk = ~clk;

    draw_addr_sweep #(
        .ADDR_W(ADDR_W), .LANES(LANES), .START_ADDR(START), .END_ADDR(END)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .loop(loop),
        .addr(addr), .valid(valid), .last(last), .wrapped(wrapped), .done(done)
    );

    draw_addr_sweep #(
        .ADDR_W(6), .LANES(4), .START_ADDR(0), .END_ADDR(16)
    ) u_small (
        .clk(clk), .reset(reset), .start(s_start), .enable(s_enable), .loop(s_loop),
        .addr(s_addr), .valid(s_valid), .last(s_last), .wrapped(s_wrapped), .done(s_done)
    );

    typedef struct packed {
        logic                    v;
        logic                    d;
        logic                    l;
        logic                    w;
        logic [LANES*ADDR_W-1:0] a;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int m_cur;
    bit m_act, m_fin, m_wr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.v = m_act;
        e.d = m_fin;
        e.l = m_act && (m_cur == END - LANES);
        e.w = m_wr;
        for (int i = 0; i < LANES; i++) e.a[i*ADDR_W +: ADDR_W] = ADDR_W'(m_cur + i);
        return e;
    endfunction

    task automatic model_reset();
        m_cur = START;
        m_act = 0;
        m_fin = 0;
        m_wr  = 0;
    endtask

    // Address-level view: lane 0 walks the window in steps of LANES
    task automatic model_step(input logic s, input logic e, input logic l);
        m_wr = 0;
        if (s) begin
            m_act = 1;
            m_fin = 0;
            m_cur = START;
        end else if (m_act && e) begin
            if (m_cur + LANES < END) begin
                m_cur = m_cur + LANES;
            end else if (l) begin
                m_cur = START;
                m_wr  = 1;
            end else begin
                m_act = 0;
                m_fin = 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic s, input logic e, input logic l);
        @(negedge clk);
        start  = s;
        enable = e;
        loop   = l;
        model_step(s, e, l);
        exp_q.push_back(model_out());
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("valid", 32'(valid), 32'(e.v));
            checkOutput("done", 32'(done), 32'(e.d));
            checkOutput("last", 32'(last), 32'(e.l));
            checkOutput("wrapped", 32'(wrapped), 32'(e.w));
            checkOutput("addr", 32'(addr), 32'(e.a));
        end
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        enable   = 1'b0;
        loop     = 1'b0;
        s_start  = 1'b0;
        s_enable = 1'b0;
        s_loop   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(valid), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_lane0", 32'(addr[0 +: ADDR_W]), 13568);
        checkOutput("rst_lane1", 32'(addr[ADDR_W +: ADDR_W]), 13569);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(0, 1, 1);
        applyStimulus(0, 1, 0);

        // One-shot sweep to DONE, then enable/loop must be ignored
        applyStimulus(1, 1, 0);
        repeat (130) applyStimulus(0, 1, 0);
        repeat (3) applyStimulus(0, 1, 1);

        // Start from DONE, then the 1,0,0,1 stall pattern
        applyStimulus(1, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 1, 0);

        for (int k = 0; k < 200 && m_cur != 13700; k++) applyStimulus(0, 1, 0);
        applyStimulus(1, 1, 0);

        repeat (300) applyStimulus(0, 1, 1);

        applyStimulus(1, 1, 1);
        for (int k = 0; k < 2500; k++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-sweep
        applyStimulus(1, 1, 1);
        repeat (20) applyStimulus(0, 1, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(valid), 0);
        checkOutput("midrst_done", 32'(done), 0);
        checkOutput("midrst_wrapped", 32'(wrapped), 0);
        checkOutput("midrst_lane0", 32'(addr[0 +: ADDR_W]), 13568);
        checkOutput("midrst_lane1", 32'(addr[ADDR_W +: ADDR_W]), 13569);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) applyStimulus(0, 1, 1);

        // Four-lane window 0..15
        @(negedge clk);
        s_start  = 1'b1;
        s_enable = 1'b1;
        s_loop   = 1'b0;
        for (int g = 0; g < 4; g++) begin
            @(posedge clk);
            #1;
            checkOutput("small_valid", 32'(s_valid), 1);
            checkOutput("small_last", 32'(s_last), (g == 3) ? 1 : 0);
            for (int i = 0; i < 4; i++) checkOutput("small_lane", 32'(s_addr[i*6 +: 6]), g * 4 + i);
            @(negedge clk);
            s_start = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("small_done", 32'(s_done), 1);
        checkOutput("small_valid_end", 32'(s_valid), 0);
        checkOutput("small_held", 32'(s_addr[0 +: 6]), 12);

        repeat (2) @(posedge clk);
        #2;
        checkOutput("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
